// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, PC step, FSM state encoding.
package rv_fetch_pkg;
  localparam int XLEN    = 32;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and flush. The head is read from registered storage.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues credit-limited imem reads, queues
// returned instructions for decode and discards stale responses after redirects.
module imem_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4,
  parameter int          CNT_W    = $clog2(FQ_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);
  localparam int QW = XLEN + INST_W;

  fetch_state_e     state;
  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W:0]   credit_sum;
  logic             pending;
  logic             credit_ok;
  logic             accept;
  logic             rsp_drop;
  logic             q_push;
  logic             q_pop;
  logic [XLEN-1:0]  tag_pc;
  logic [QW-1:0]    q_head;
  logic [QW-1:0]    hold;

  // Outstanding requests plus queued words never exceed the queue depth, so responses need no backpressure.
  assign credit_sum = {1'b0, outstanding} + {1'b0, q_count};
  assign credit_ok  = credit_sum < (CNT_W + 1)'(FQ_DEPTH);

  assign imem_req_valid = (state == FETCH) && credit_ok && !redirect_valid && (fetch_en || pending);
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign q_push         = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign q_pop          = if_valid && if_ready && !redirect_valid;

  assign if_valid = (q_count != '0);
  assign if_pc    = if_valid ? q_head[QW-1:INST_W] : hold[QW-1:INST_W];
  assign if_inst  = if_valid ? q_head[INST_W-1:0]  : hold[INST_W-1:0];

  // The tag FIFO's occupancy is exactly the number of accepted-but-unanswered requests.
  sync_fifo #(.W(XLEN), .DEPTH(FQ_DEPTH), .CW(CNT_W)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (accept),
    .din   (pc),
    .pop   (imem_rsp_valid),
    .dout  (tag_pc),
    .count (outstanding)
  );

  sync_fifo #(.W(QW), .DEPTH(FQ_DEPTH), .CW(CNT_W)) u_fetch_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (q_push),
    .din   ({tag_pc, imem_rsp_data}),
    .pop   (q_pop),
    .dout  (q_head),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pending  <= 1'b0;
      drop_cnt <= '0;
      hold     <= '0;
    end else begin
      if (redirect_valid)
        pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (accept)
        pc <= pc + XLEN'(PC_STEP);

      pending <= imem_req_valid && !imem_req_ready;

      // Everything still in flight after a redirect cycle belongs to the old stream.
      if (redirect_valid)
        drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
      else if (rsp_drop)
        drop_cnt <= drop_cnt - 1'b1;

      if (if_valid) hold <= q_head;

      case (state)
        IDLE:    if (fetch_en) state <= FETCH;
        FETCH:   if (!fetch_en && !(imem_req_valid && !imem_req_ready)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with an in-order memory model of configurable latency.
module tb_imem_fetch_ctrl;
  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] dq_pc[$];
  logic [31:0] dq_inst[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_acc = 0;
  int          first_acc = -1;
  int          first_val = -1;
  logic [31:0] first_acc_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: memory model drives its response, then accepts and decode pops are recorded.
  task automatic cycle();
    if (!rst_n) memq.delete();
    if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      memq.push_back('{addr: imem_addr, due: cyc + lat});
      if (n_acc == 0) first_acc_addr = imem_addr;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (rst_n && if_valid && first_val < 0) first_val = cyc;
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      dq_pc.push_back(if_pc);
      dq_inst.push_back(if_inst);
      $display("cyc %0d decode pc=%h inst=%h", cyc, if_pc, if_inst);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    check({tag, "_rst_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_rst_if_valid"}, if_valid, 1'b0);
    check({tag, "_rst_if_inst"}, if_inst, 32'h0);
    check({tag, "_rst_if_pc"}, if_pc, 32'h0);
    rst_n = 1'b1;
    cyc = 0;
    n_acc = 0;
    first_acc = -1;
    first_val = -1;
    memq.delete();
    dq_pc.delete();
    dq_inst.delete();
  endtask

  task automatic check_stream(input string tag, input logic [31:0] start, input int n);
    logic [31:0] exp_pc;
    check({tag, "_len"}, dq_pc.size() >= n, 1'b1);
    exp_pc = start;
    for (int i = 0; i < n; i++) begin
      if (i < dq_pc.size()) begin
        check($sformatf("%s_pc%0d", tag, i), dq_pc[i], exp_pc);
        check($sformatf("%s_inst%0d", tag, i), dq_inst[i], mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if_ready = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with a single-cycle memory.
    lat = 1;
    do_reset("t1");
    fetch_en = 1'b1;
    run(12);
    check("t1_first_latency", first_val - first_acc, 2);
    check_stream("t1", 32'h0, 8);

    // Decode stall: the queue fills to depth and then drains in order.
    do_reset("t2");
    if_ready = 1'b0;
    run(10);
    check("t2_accepts", n_acc, 4);
    check("t2_req_blocked", imem_req_valid, 1'b0);
    check("t2_if_valid", if_valid, 1'b1);
    check("t2_head_pc", if_pc, 32'h0);
    check("t2_head_inst", if_inst, mem_word(32'h0));
    if_ready = 1'b1;
    run(10);
    check_stream("t2", 32'h0, 6);

    // Redirect with three fetches in flight on a 3-cycle memory.
    lat = 3;
    do_reset("t3");
    run(4);
    check("t3_inflight", memq.size(), 3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    run(20);
    check_stream("t3", 32'h0000_0100, 4);

    // Back-to-back redirects: the later target wins.
    lat = 1;
    do_reset("t4");
    run(6);
    dq_pc.delete();
    dq_inst.delete();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    cycle();
    redirect_pc = 32'h0000_0300;
    cycle();
    redirect_valid = 1'b0;
    run(10);
    check_stream("t4", 32'h0000_0300, 5);

    // A request stuck without ready is held even after fetch_en drops.
    do_reset("t5");
    imem_req_ready = 1'b0;
    run(5);
    check("t5_held_valid", imem_req_valid, 1'b1);
    check("t5_held_addr", imem_addr, 32'h0);
    fetch_en = 1'b0;
    cycle();
    check("t5_hold_after_en_low", imem_req_valid, 1'b1);
    check("t5_addr_after_en_low", imem_addr, 32'h0);
    imem_req_ready = 1'b1;
    cycle();
    run(6);
    check("t5_accepts", n_acc, 1);
    check("t5_idle_no_req", imem_req_valid, 1'b0);
    check_stream("t5", 32'h0, 1);

    // PC wrap at the top of the address space, then reset mid-stream.
    do_reset("t6");
    fetch_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFA;
    cycle();
    redirect_valid = 1'b0;
    run(8);
    check_stream("t6", 32'hFFFF_FFF8, 4);
    do_reset("t6mid");
    for (int i = 0; i < 10 && n_acc == 0; i++) cycle();
    check("t6_req_after_reset", n_acc > 0, 1'b1);
    check("t6_reset_pc", first_acc_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
